// File: rtl/noc_out_arb_pkg.sv
// Shared defaults and FSM encodings for the NoC output-port arbiter and its
// round-robin picker.
package noc_out_arb_pkg;

  localparam int unsigned NUM_IN_DEF = 4;
  localparam int unsigned FLIT_W_DEF = 32;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_LOCK = 1'b1;

endpackage

// File: rtl/noc_out_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_IN. Shared by all router output ports.
module noc_rr_pick
  import noc_out_arb_pkg::*;
#(
  parameter  int unsigned NUM_IN = NUM_IN_DEF,
  localparam int unsigned ID_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  logic [2*NUM_IN-1:0] dbl;
  logic [2*NUM_IN-1:0] masked;

  // Masking the low copy below ptr leaves the high copy to supply the wrap.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*NUM_IN){1'b1}} << ptr);
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 2*NUM_IN; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = ID_W'(i % NUM_IN);
      end
    end
  end

endmodule

// File: rtl/noc_out_arb.sv
// Round-robin, packet-locking (wormhole) arbiter for one router output port,
// with a clock-enabled output register stage.
module noc_out_arb
  import noc_out_arb_pkg::*;
#(
  parameter  int unsigned NUM_IN = NUM_IN_DEF,
  parameter  int unsigned FLIT_W = FLIT_W_DEF,
  localparam int unsigned ID_W   = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  input  logic [NUM_IN-1:0]        in_tail,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_tail,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  logic [0:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              load_en;
  logic              xfer;
  logic              owner_valid;
  logic              owner_tail;
  logic [FLIT_W-1:0] owner_flit;

  noc_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (winner)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_tail  = 1'b0;
    owner_flit  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = in_valid[i];
        owner_tail  = in_tail[i];
        owner_flit  = in_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign busy     = (state == ARB_LOCK);
  assign grant_id = owner;
  assign load_en  = !out_valid || out_ready;
  assign xfer     = busy && owner_valid && load_en;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (busy && owner == ID_W'(i)) in_ready[i] = load_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            owner <= winner;
            state <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          // Pointer moves only on a tail transfer, so each owner is passed over next time.
          if (xfer && owner_tail) begin
            state  <= ARB_IDLE;
            rr_ptr <= (owner == ID_W'(NUM_IN-1)) ? '0 : owner + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_tail  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_flit  <= owner_flit;
      out_tail  <= owner_tail;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_out_arb.sv
// Directed bench for noc_out_arb: per-cycle expectation tables driven by a
// simple upstream packet source per requester.
module tb_noc_out_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [127:0] in_flit;
  logic [3:0]   in_tail;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_flit;
  logic         out_tail;
  logic         out_ready;
  logic [1:0]   grant_id;
  logic         busy;

  int errors = 0;
  int checks = 0;

  int unsigned pkts [4];
  int unsigned cnt  [4];
  int unsigned len  [4];
  logic [31:0] base [4];

  typedef struct packed {
    logic       ordy;
    logic       bsy;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       ov;
    logic       tl;
    logic [7:0] fl;
  } exp_t;

  noc_out_arb #(.NUM_IN(4), .FLIT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_tail   (in_tail),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_tail  (out_tail),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t e(input logic o, input logic b, input logic [1:0] g,
                             input logic [3:0] r, input logic v, input logic tl,
                             input logic [7:0] f);
    return {o, b, g, r, v, tl, f};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]         = (pkts[i] != 0);
      in_flit[i*32 +: 32] = base[i] + cnt[i];
      in_tail[i]          = (cnt[i] == len[i] - 1);
    end
  endtask

  task automatic src_clear();
    for (int i = 0; i < 4; i++) begin
      pkts[i] = 0;
      cnt[i]  = 0;
      len[i]  = 1;
      base[i] = 32'h0;
    end
    drive();
  endtask

  // Advance one clock; the source consumes whatever was accepted at that edge.
  task automatic step();
    logic [3:0] acc;
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        if (in_tail[i]) begin
          cnt[i]  = 0;
          pkts[i] = pkts[i] - 1;
        end else begin
          cnt[i] = cnt[i] + 1;
        end
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    src_clear();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    src_clear();
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    #1;
    checks++;
    if ({out_valid, busy, in_ready, grant_id, out_tail} !== 9'b0 || out_flit !== 32'h0) begin
      $display("FAIL reset_state: valid=%b busy=%b rdy=%b gid=%0d tail=%b flit=%h, want all zero",
               out_valid, busy, in_ready, grant_id, out_tail, out_flit);
      errors++;
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0) begin
        $display("FAIL idle_no_req c%0d: valid=%b busy=%b rdy=%b, want 0 0 0000",
                 c, out_valid, busy, in_ready);
        errors++;
      end
    end
  endtask

  task automatic test_two_req();
    exp_t t [9];
    pkts[1] = 1; len[1] = 3; base[1] = 32'h1A;
    pkts[2] = 1; len[2] = 3; base[2] = 32'h2A;
    drive();
    t[0] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00);
    t[1] = e(1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 8'h00);
    t[2] = e(1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 8'h1A);
    t[3] = e(1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 8'h1B);
    t[4] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h1C);
    t[5] = e(1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 8'h00);
    t[6] = e(1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 8'h2A);
    t[7] = e(1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 8'h2B);
    t[8] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h2C);
    for (int c = 0; c < 9; c++) begin
      if (c != 0) step();
      out_ready = t[c].ordy;
      #1;
      checks++;
      if (busy !== t[c].bsy || (t[c].bsy && grant_id !== t[c].gid) || in_ready !== t[c].rdy ||
          out_valid !== t[c].ov || (t[c].ov && (out_flit !== {24'h0, t[c].fl} || out_tail !== t[c].tl))) begin
        $display("FAIL two_req c%0d: busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b, want busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b",
                 c, busy, grant_id, in_ready, out_valid, out_flit, out_tail,
                 t[c].bsy, t[c].gid, t[c].rdy, t[c].ov, t[c].fl, t[c].tl);
        errors++;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t t [7];
    pkts[3] = 1; len[3] = 2; base[3] = 32'h3A;
    pkts[0] = 1; len[0] = 2; base[0] = 32'h0A;
    drive();
    t[0] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h2C);
    t[1] = e(1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0, 8'h00);
    t[2] = e(1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 8'h3A);
    t[3] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h3B);
    t[4] = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 8'h00);
    t[5] = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'h0A);
    t[6] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h0B);
    for (int c = 0; c < 7; c++) begin
      if (c != 0) step();
      out_ready = t[c].ordy;
      #1;
      checks++;
      if (busy !== t[c].bsy || (t[c].bsy && grant_id !== t[c].gid) || in_ready !== t[c].rdy ||
          out_valid !== t[c].ov || (t[c].ov && (out_flit !== {24'h0, t[c].fl} || out_tail !== t[c].tl))) begin
        $display("FAIL wrap c%0d: busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b, want busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b",
                 c, busy, grant_id, in_ready, out_valid, out_flit, out_tail,
                 t[c].bsy, t[c].gid, t[c].rdy, t[c].ov, t[c].fl, t[c].tl);
        errors++;
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t t [9];
    do_reset();
    pkts[0] = 1; len[0] = 3; base[0] = 32'hA0;
    drive();
    t[0] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00);
    t[1] = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 8'h00);
    t[2] = e(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 8'hA0);
    t[3] = e(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 8'hA0);
    t[4] = e(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 8'hA0);
    t[5] = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'hA0);
    t[6] = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'hA1);
    t[7] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'hA2);
    t[8] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 9; c++) begin
      if (c != 0) step();
      out_ready = t[c].ordy;
      #1;
      checks++;
      if (busy !== t[c].bsy || (t[c].bsy && grant_id !== t[c].gid) || in_ready !== t[c].rdy ||
          out_valid !== t[c].ov || (t[c].ov && (out_flit !== {24'h0, t[c].fl} || out_tail !== t[c].tl))) begin
        $display("FAIL backpressure c%0d: busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b, want busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b",
                 c, busy, grant_id, in_ready, out_valid, out_flit, out_tail,
                 t[c].bsy, t[c].gid, t[c].rdy, t[c].ov, t[c].fl, t[c].tl);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t t [11];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pkts[i] = 1;
      len[i]  = 1;
    end
    pkts[0] = 2;
    base[0] = 32'h0A; base[1] = 32'h1A; base[2] = 32'h2A; base[3] = 32'h3A;
    drive();
    t[0]  = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00);
    t[1]  = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 8'h00);
    t[2]  = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h0A);
    t[3]  = e(1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 8'h00);
    t[4]  = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h1A);
    t[5]  = e(1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 8'h00);
    t[6]  = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h2A);
    t[7]  = e(1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0, 8'h00);
    t[8]  = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h3A);
    t[9]  = e(1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 8'h00);
    t[10] = e(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 8'h0A);
    for (int c = 0; c < 11; c++) begin
      if (c != 0) step();
      out_ready = t[c].ordy;
      #1;
      checks++;
      if (busy !== t[c].bsy || (t[c].bsy && grant_id !== t[c].gid) || in_ready !== t[c].rdy ||
          out_valid !== t[c].ov || (t[c].ov && (out_flit !== {24'h0, t[c].fl} || out_tail !== t[c].tl))) begin
        $display("FAIL back_to_back c%0d: busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b, want busy=%b gid=%0d rdy=%b ov=%b flit=%h tail=%b",
                 c, busy, grant_id, in_ready, out_valid, out_flit, out_tail,
                 t[c].bsy, t[c].gid, t[c].rdy, t[c].ov, t[c].fl, t[c].tl);
        errors++;
      end
    end
  endtask

  // Runs straight after back_to_back, so the pointer sits at 1 going in.
  task automatic test_reset_mid_packet();
    pkts[2] = 1; len[2] = 3; base[2] = 32'h5A;
    drive();
    step();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || in_ready !== 4'b0100) begin
      $display("FAIL midrst_grant: busy=%b gid=%0d rdy=%b, want 1 2 0100", busy, grant_id, in_ready);
      errors++;
    end
    step();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_flit !== 32'h5A) begin
      $display("FAIL midrst_first_flit: ov=%b flit=%h, want 1 0000005a", out_valid, out_flit);
      errors++;
    end
    pkts[0] = 1; len[0] = 2; base[0] = 32'h7A;
    rst = 1'b1;
    drive();
    step();
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0 || grant_id !== 2'd0 ||
        out_tail !== 1'b0 || out_flit !== 32'h0) begin
      $display("FAIL midrst_cleared: ov=%b busy=%b rdy=%b gid=%0d tail=%b flit=%h, want all zero",
               out_valid, busy, in_ready, grant_id, out_tail, out_flit);
      errors++;
    end
    cnt[2] = 0;
    rst = 1'b0;
    drive();
    step();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || in_ready !== 4'b0001) begin
      $display("FAIL midrst_regrant: busy=%b gid=%0d rdy=%b, want 1 0 0001", busy, grant_id, in_ready);
      errors++;
    end
    step();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_flit !== 32'h7A || out_tail !== 1'b0) begin
      $display("FAIL midrst_new_flit: ov=%b flit=%h tail=%b, want 1 0000007a 0", out_valid, out_flit, out_tail);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
